// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Two's-complement negate at the widest supported width; callers truncate to WIDTH.
  function automatic logic [MAX_WIDTH-1:0] twos_neg(input logic [MAX_WIDTH-1:0] x);
    return ~x + MAX_WIDTH'(1);
  endfunction

  // Magnitude of a value whose sign is supplied separately (zero-extended operand).
  function automatic logic [MAX_WIDTH-1:0] twos_abs(input logic [MAX_WIDTH-1:0] x,
                                                    input logic              neg);
    return neg ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] mag_b_i,
  output logic [WIDTH-1:0] rem_c,
  output logic             q_bit_c
);

  // The shifted remainder keeps its top bit so large unsigned divisors are not truncated.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH+1:0] sel;
  logic             unused_hi;

  // Trial subtract with one guard bit; its sign decides the quotient bit.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = {1'b0, shifted} - {2'b00, mag_b_i};
    q_bit_c = ~diff[WIDTH+1];
    sel     = q_bit_c ? diff : {1'b0, shifted};
    rem_c   = sel[WIDTH-1:0];
  end

  // The result always fits in WIDTH bits because rem < mag_b on entry.
  assign unused_hi = ^sel[WIDTH+1:WIDTH];

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per cycle.
module div_seq_param
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int unsigned    CNT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

  div_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dz_out_q, dz_out_d;
  logic             ov_out_q, ov_out_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] step_rem_c;
  logic             step_q_c;
  logic             ovf_c;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .bit_i   (mag_a_q[cnt_q]),
    .mag_b_i (mag_b_q),
    .rem_c   (step_rem_c),
    .q_bit_c (step_q_c)
  );

  // MIN / -1 is the only signed case whose true quotient does not fit.
  assign ovf_c = sign_a_q & sign_b_q & (a_q == MIN_VAL) & (mag_b_q == ONE_VAL);

  // Next-state and datapath updates for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    quot_d   = quot_q;
    remd_d   = remd_q;
    dz_out_d = dz_out_q;
    ov_out_d = ov_out_q;
    a_d      = a_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_d    = rem_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          sign_a_d = is_signed & a[WIDTH-1];
          sign_b_d = is_signed & b[WIDTH-1];
          mag_a_d  = WIDTH'(twos_abs(MAX_WIDTH'(a), is_signed & a[WIDTH-1]));
          mag_b_d  = WIDTH'(twos_abs(MAX_WIDTH'(b), is_signed & b[WIDTH-1]));
          rem_d    = '0;
          q_d      = '0;
          cnt_d    = CNT_W'(WIDTH - 1);
          if (b == '0) begin
            zero_d  = 1'b1;
            state_d = FIX;
          end else begin
            zero_d   = 1'b0;
            dz_out_d = 1'b0;
            ov_out_d = 1'b0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d        = step_rem_c;
          q_d[cnt_q]   = step_q_c;
          cnt_d        = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (zero_q) begin
            quot_d   = '1;
            remd_d   = a_q;
            dz_out_d = 1'b1;
            ov_out_d = 1'b0;
          end else begin
            quot_d   = (sign_a_q ^ sign_b_q) ? WIDTH'(twos_neg(MAX_WIDTH'(q_q))) : q_q;
            remd_d   = sign_a_q ? WIDTH'(twos_neg(MAX_WIDTH'(rem_q))) : rem_q;
            dz_out_d = 1'b0;
            ov_out_d = ovf_c;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      remd_q   <= '0;
      dz_out_q <= 1'b0;
      ov_out_q <= 1'b0;
      a_q      <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      remd_q   <= remd_d;
      dz_out_q <= dz_out_d;
      ov_out_q <= ov_out_d;
      a_q      <= a_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remd_q;
  assign div_zero  = dz_out_q;
  assign overflow  = ov_out_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: 32-bit and 8-bit instances checked against an arithmetic model.
module tb_div_seq_param;

  logic        clk;
  logic        reset;
  logic        abort;
  logic        sgn_in;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        start32, start8;

  logic        busy32, done32, dz32, ov32;
  logic [31:0] q32, r32;
  logic        busy8, done8, dz8, ov8;
  logic [7:0]  q8, r8;

  int errors;
  int checks;
  logic [63:0] last_q32, last_r32, last_q8, last_r8;

  div_seq_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .abort(abort), .is_signed(sgn_in),
    .a(a_in[31:0]), .b(b_in[31:0]), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_zero(dz32), .overflow(ov32)
  );

  div_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .abort(abort), .is_signed(sgn_in),
    .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_zero(dz8), .overflow(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done32;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy32;
  endfunction
  function automatic logic [63:0] get_q(input int w);
    return (w == 8) ? 64'(q8) : 64'(q32);
  endfunction
  function automatic logic [63:0] get_r(input int w);
    return (w == 8) ? 64'(r8) : 64'(r32);
  endfunction
  function automatic logic get_dz(input int w);
    return (w == 8) ? dz8 : dz32;
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov32;
  endfunction

  // Reference: plain integer division with SV's truncating / and %.
  task automatic ref_div(input int w, input logic sgn, input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic dz, output logic ov);
    longint sa, sb, minv;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    dz = 1'b0;
    ov = 1'b0;
    if (bv == 64'd0) begin
      q  = mask;
      r  = av;
      dz = 1'b1;
    end else if (sgn) begin
      if (w == 8) begin
        sa = longint'($signed(av[7:0]));
        sb = longint'($signed(bv[7:0]));
      end else begin
        sa = longint'($signed(av[31:0]));
        sb = longint'($signed(bv[31:0]));
      end
      minv = -(longint'(1) <<< (w - 1));
      if (sa == minv && sb == -1) begin
        q  = av;
        r  = 64'd0;
        ov = 1'b1;
      end else begin
        q = 64'(sa / sb) & mask;
        r = 64'(sa % sb) & mask;
      end
    end else begin
      q = av / bv;
      r = av % bv;
    end
  endtask

  // Launch one division, track busy/done timing cycle by cycle, then compare results.
  task automatic run_op(input int w, input logic sgn, input logic [63:0] a_raw,
                        input logic [63:0] b_raw, input string tag);
    logic [63:0] mask, av, bv, eq, er, prev_q;
    logic        edz, eov;
    int          lat, done_at, busy_bad;
    mask = (64'd1 << w) - 64'd1;
    av   = a_raw & mask;
    bv   = b_raw & mask;
    ref_div(w, sgn, av, bv, eq, er, edz, eov);
    lat    = (bv == 64'd0) ? 2 : w + 2;
    prev_q = (w == 8) ? last_q8 : last_q32;

    @(negedge clk);
    a_in   = av;
    b_in   = bv;
    sgn_in = sgn;
    if (w == 8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start32 = 1'b0;

    chk({tag, "_q_hold"}, get_q(w), prev_q);
    if (bv != 64'd0) begin
      chk({tag, "_flags_clr"}, {62'd0, get_dz(w), get_ov(w)}, 64'd0);
    end

    done_at  = 0;
    busy_bad = 0;
    for (int k = 1; k <= w + 8 && done_at == 0; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (get_done(w)) done_at = k;
      else if (get_busy(w) != (k < lat)) busy_bad++;
    end

    chk({tag, "_busy_seq"}, 64'(busy_bad), 64'd0);
    chk({tag, "_lat"}, 64'(done_at), 64'(lat));
    chk({tag, "_busy_at_done"}, 64'(get_busy(w)), 64'd0);
    chk({tag, "_quot"}, get_q(w), eq);
    chk({tag, "_rem"}, get_r(w), er);
    chk({tag, "_dz"}, 64'(get_dz(w)), 64'(edz));
    chk({tag, "_ov"}, 64'(get_ov(w)), 64'(eov));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(get_done(w)), 64'd0);

    if (w == 8) begin
      last_q8 = eq;
      last_r8 = er;
    end else begin
      last_q32 = eq;
      last_r32 = er;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] av, bv;
    logic        seen_done;
    errors   = 0;
    checks   = 0;
    last_q32 = '0;
    last_r32 = '0;
    last_q8  = '0;
    last_r8  = '0;
    reset    = 1'b0;
    abort    = 1'b0;
    sgn_in   = 1'b0;
    a_in     = '0;
    b_in     = '0;
    start32  = 1'b0;
    start8   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'({busy32, busy8}), 64'd0);
    chk("rst_done", 64'({done32, done8}), 64'd0);
    chk("rst_quot32", 64'(q32), 64'd0);
    chk("rst_rem32", 64'(r32), 64'd0);
    chk("rst_flags", 64'({dz32, ov32, dz8, ov8}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(32, 1'b0, 64'd100, 64'd7, "t1");
    run_op(32, 1'b1, 64'hFFFF_FFF9, 64'd2, "t2a");
    run_op(32, 1'b1, 64'd7, 64'hFFFF_FFFE, "t2b");
    run_op(32, 1'b0, 64'd5, 64'd0, "t3a");
    run_op(32, 1'b1, 64'd5, 64'd0, "t3b");
    run_op(32, 1'b0, 64'd40, 64'd6, "t3c");
    run_op(32, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "t4a");
    run_op(32, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, "t4b");
    run_op(32, 1'b0, 64'd100, 64'd7, "t5pre");

    // Abort in flight; an extra start mid-operation must be ignored.
    @(negedge clk);
    a_in = 64'd100; b_in = 64'd7; sgn_in = 1'b0; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32   = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (done32) seen_done = 1'b1;
      if (k == 10) chk("t5_busy_before_abort", 64'(busy32), 64'd1);
      if (k == 11) chk("t5_busy_after_abort", 64'(busy32), 64'd0);
      start32 = (k == 5);
      if (k == 5) begin
        a_in = 64'd9;
        b_in = 64'd3;
      end
      abort = (k == 10);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32) seen_done = 1'b1;
    end
    chk("t5_abort_no_done", 64'(seen_done), 64'd0);
    chk("t5_abort_quot", 64'(q32), last_q32);
    chk("t5_abort_rem", 64'(r32), last_r32);
    chk("t5_abort_flags", 64'({dz32, ov32}), 64'd0);

    // Reset pulled mid-operation clears everything at once.
    @(negedge clk);
    a_in = 64'd100; b_in = 64'd7; sgn_in = 1'b0; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy32), 64'd0);
    chk("t5_rst_quot", 64'(q32), 64'd0);
    chk("t5_rst_rem", 64'(r32), 64'd0);
    chk("t5_rst_misc", 64'({done32, dz32, ov32}), 64'd0);
    @(negedge clk);
    reset     = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32) seen_done = 1'b1;
    end
    chk("t5_rst_no_done", 64'(seen_done), 64'd0);
    last_q32 = '0;
    last_r32 = '0;

    run_op(8, 1'b0, 64'hFF, 64'h10, "t6a");
    run_op(8, 1'b1, 64'h80, 64'h03, "t6b");
    run_op(8, 1'b1, 64'h80, 64'hFF, "t6c");
    run_op(8, 1'b0, 64'h80, 64'hFF, "t6d");

    for (int i = 0; i < 30; i++) begin
      av = 64'($urandom);
      if ($urandom_range(0, 7) == 0) av = 64'h8000_0000;
      case ($urandom_range(0, 5))
        0:       bv = 64'd0;
        1:       bv = 64'($urandom_range(1, 15));
        2:       bv = 64'hFFFF_FFFF;
        3:       bv = 64'($urandom_range(1, 65535));
        default: bv = 64'($urandom);
      endcase
      run_op(32, 1'($urandom_range(0, 1)), av, bv, "rnd32");
    end

    for (int i = 0; i < 30; i++) begin
      av = 64'($urandom_range(0, 255));
      bv = ($urandom_range(0, 6) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      run_op(8, 1'($urandom_range(0, 1)), av, bv, "rnd8");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
